// File: rtl/issue_dispatcher_if.sv
// Issue-stage bus between the instruction queue, the dispatcher and the CDB/RS side.
// Groups the queue handshake (in_valid/stall plus instruction fields), station release,
// CDB snoop and the registered issue outputs.
//   master : drives the instruction, release and CDB inputs; observes stall and issue_*.
//   slave  : the dispatcher itself.
interface issue_dispatcher_if #(
    parameter int unsigned TAG_W = 3
);
    logic             in_valid;
    logic [2:0]       opcode;
    logic [2:0]       rx;
    logic [2:0]       ry;
    logic [2:0]       rz;
    logic [3:0]       immediate;
    logic             rs_release;
    logic [TAG_W-1:0] rs_rel_tag;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic             stall;
    logic             issue_valid;
    logic [TAG_W-1:0] issue_tag;
    logic [2:0]       issue_op;
    logic [2:0]       issue_rj;
    logic [2:0]       issue_rk;
    logic [TAG_W-1:0] issue_qj;
    logic [TAG_W-1:0] issue_qk;
    logic [3:0]       issue_imm;
    logic             illegal_op;
    logic [7:0]       issue_count;

    modport master (
        output in_valid, opcode, rx, ry, rz, immediate,
        output rs_release, rs_rel_tag, cdb_valid, cdb_tag,
        input  stall, issue_valid, issue_tag, issue_op, issue_rj, issue_rk,
        input  issue_qj, issue_qk, issue_imm, illegal_op, issue_count
    );

    modport slave (
        input  in_valid, opcode, rx, ry, rz, immediate,
        input  rs_release, rs_rel_tag, cdb_valid, cdb_tag,
        output stall, issue_valid, issue_tag, issue_op, issue_rj, issue_rk,
        output issue_qj, issue_qk, issue_imm, illegal_op, issue_count
    );
endinterface

// File: rtl/issue_dispatcher.sv
// Tomasulo issue stage. Takes one decoded instruction per cycle, allocates the
// lowest free reservation station of its class (ALU: ADD/SUB, MEM: LD/SD), looks up
// source producer tags in an 8-entry register status table (Qi), renames the
// destination, and snoops the CDB to clear completed tags.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   bus          : issue_dispatcher_if.slave (instruction in, stall out, release,
//                  CDB snoop, registered issue_* / illegal_op pulses, issue_count)
module issue_dispatcher #(
    parameter int unsigned NUM_ALU_RS = 2,
    parameter int unsigned NUM_MEM_RS = 2,
    parameter int unsigned TAG_W      = 3
) (
    input logic               clock,
    input logic               reset,
    issue_dispatcher_if.slave bus
);
    localparam int unsigned NUM_RS = NUM_ALU_RS + NUM_MEM_RS;

    typedef logic [TAG_W-1:0] tag_t;

    logic [NUM_RS-1:0] busy_q, busy_d;   // bit i = station with tag i+1
    tag_t              qi_q [8];
    tag_t              qi_d [8];

    logic       op_legal, op_alu, op_sd, has_dest;
    logic       alu_free, mem_free, cls_free;
    tag_t       alu_tag, mem_tag, alloc_tag;
    logic       accept, do_issue, do_illegal;
    tag_t       src_j, src_k, qj, qk;
    logic [2:0] rk;

    logic       issue_valid_q, illegal_q;
    tag_t       issue_tag_q, issue_qj_q, issue_qk_q;
    logic [2:0] issue_op_q, issue_rj_q, issue_rk_q;
    logic [3:0] issue_imm_q;
    logic [7:0] issue_count_q;

    assign op_legal = ~bus.opcode[2];
    assign op_alu   = bus.opcode[2:1] == 2'b00;
    assign op_sd    = bus.opcode == 3'b011;
    assign has_dest = op_legal & ~op_sd;

    // Lowest-numbered free station per class; scan downward so the lowest wins.
    always_comb begin
        alu_free = 1'b0;
        alu_tag  = '0;
        for (int i = int'(NUM_ALU_RS) - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                alu_free = 1'b1;
                alu_tag  = tag_t'(i + 1);
            end
        end
        mem_free = 1'b0;
        mem_tag  = '0;
        for (int i = int'(NUM_RS) - 1; i >= int'(NUM_ALU_RS); i--) begin
            if (!busy_q[i]) begin
                mem_free = 1'b1;
                mem_tag  = tag_t'(i + 1);
            end
        end
    end

    assign cls_free   = op_alu ? alu_free : mem_free;
    assign alloc_tag  = op_alu ? alu_tag : mem_tag;
    // Depends only on registered busy bits and current inputs.
    assign bus.stall  = bus.in_valid & op_legal & ~cls_free;
    assign accept     = bus.in_valid & ~bus.stall;
    assign do_issue   = accept & op_legal;
    assign do_illegal = accept & ~op_legal;

    // Source lookup uses Qi before this instruction's rename; a matching CDB
    // broadcast in the same cycle forwards as "value ready" (tag 0).
    always_comb begin
        src_j = qi_q[bus.ry];
        src_k = '0;
        rk    = '0;
        unique case (bus.opcode[1:0])
            2'b00, 2'b01: begin src_k = qi_q[bus.rz]; rk = bus.rz; end
            2'b11:        begin src_k = qi_q[bus.rx]; rk = bus.rx; end
            default:      begin src_k = '0;           rk = '0;     end
        endcase
        qj = (bus.cdb_valid && src_j == bus.cdb_tag) ? '0 : src_j;
        qk = (bus.cdb_valid && src_k == bus.cdb_tag) ? '0 : src_k;
    end

    // CDB clear first, then rename, so a same-cycle rename wins.
    always_comb begin
        for (int r = 0; r < 8; r++) begin
            qi_d[r] = qi_q[r];
            if (bus.cdb_valid && qi_q[r] == bus.cdb_tag) qi_d[r] = '0;
            if (do_issue && has_dest && bus.rx == 3'(r)) qi_d[r] = alloc_tag;
        end
        busy_d = busy_q;
        for (int i = 0; i < int'(NUM_RS); i++) begin
            if (bus.rs_release && bus.rs_rel_tag == tag_t'(i + 1)) busy_d[i] = 1'b0;
            if (do_issue && alloc_tag == tag_t'(i + 1)) busy_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q        <= '0;
            for (int r = 0; r < 8; r++) qi_q[r] <= '0;
            issue_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
            issue_tag_q   <= '0;
            issue_op_q    <= '0;
            issue_rj_q    <= '0;
            issue_rk_q    <= '0;
            issue_qj_q    <= '0;
            issue_qk_q    <= '0;
            issue_imm_q   <= '0;
            issue_count_q <= '0;
        end else begin
            busy_q        <= busy_d;
            for (int r = 0; r < 8; r++) qi_q[r] <= qi_d[r];
            issue_valid_q <= do_issue;
            illegal_q     <= do_illegal;
            if (do_issue) begin
                issue_tag_q   <= alloc_tag;
                issue_op_q    <= bus.opcode;
                issue_rj_q    <= bus.ry;
                issue_rk_q    <= rk;
                issue_qj_q    <= qj;
                issue_qk_q    <= qk;
                issue_imm_q   <= bus.immediate;
                issue_count_q <= issue_count_q + 8'd1;
            end
        end
    end

    assign bus.issue_valid = issue_valid_q;
    assign bus.issue_tag   = issue_tag_q;
    assign bus.issue_op    = issue_op_q;
    assign bus.issue_rj    = issue_rj_q;
    assign bus.issue_rk    = issue_rk_q;
    assign bus.issue_qj    = issue_qj_q;
    assign bus.issue_qk    = issue_qk_q;
    assign bus.issue_imm   = issue_imm_q;
    assign bus.illegal_op  = illegal_q;
    assign bus.issue_count = issue_count_q;
endmodule
